// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the matrix-multiply engine: the controller state
// encoding, a constant-foldable ceil(log2) helper and the accumulator width
// rule used to size the C elements.
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,   // issuing (i,j,k) triples
        ST_DRAIN = 2'd1,   // issue finished, pipeline emptying
        ST_DONE  = 2'd2    // all of C written; terminal until reset
    } state_e;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A C element is a sum of size products of two data_w-bit values.
    function automatic int acc_width(input int data_w, input int size);
        return 2 * data_w + clog2(size);
    endfunction

endpackage

// File: rtl/mac_pe.sv
// ---------------------------------------------------------------------------
// mac_pe
// Multiply-accumulate datapath: S2 registers the product of the S1 operands,
// S3 accumulates it. A product tagged first-k is loaded rather than added, so
// no partial sum leaks from one C element into the next.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_valid/first/last    S1 operand valid and first-k / last-k tags
//   in_row, in_col         C element the operands belong to
//   in_a, in_b             operands A[i][k], B[k][j]
//   out_valid              S3 holds a completed C element (last-k term added)
//   out_row, out_col       index of that element
//   out_acc                its value
// ---------------------------------------------------------------------------
module mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [IDX_W-1:0]  in_row,
    input  logic [IDX_W-1:0]  in_col,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic [ACC_W-1:0]  out_acc
);

    localparam int PROD_W = 2 * DATA_W;

    // S2: product stage
    logic              p_valid_q, p_valid_d;
    logic              p_first_q, p_first_d;
    logic              p_last_q,  p_last_d;
    logic [IDX_W-1:0]  p_row_q,   p_row_d;
    logic [IDX_W-1:0]  p_col_q,   p_col_d;
    logic [PROD_W-1:0] prod_q,    prod_d;

    // S3: accumulate stage
    logic              acc_valid_q, acc_valid_d;
    logic              acc_last_q,  acc_last_d;
    logic [IDX_W-1:0]  acc_row_q,   acc_row_d;
    logic [IDX_W-1:0]  acc_col_q,   acc_col_d;
    logic [ACC_W-1:0]  acc_q,       acc_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        p_valid_d   = in_valid;
        p_first_d   = in_first;
        p_last_d    = in_last;
        p_row_d     = in_row;
        p_col_d     = in_col;
        prod_d      = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};

        acc_valid_d = p_valid_q;
        acc_last_d  = p_last_q;
        acc_row_d   = p_row_q;
        acc_col_d   = p_col_q;
        acc_d       = acc_q;
        if (p_valid_q) begin
            acc_d = p_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
        end
    end

    // NOTE: flops use non-blocking '<=' so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_row_q     <= '0;
            p_col_q     <= '0;
            prod_q      <= '0;
            acc_valid_q <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_row_q   <= '0;
            acc_col_q   <= '0;
            acc_q       <= '0;
        end else begin
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            p_row_q     <= p_row_d;
            p_col_q     <= p_col_d;
            prod_q      <= prod_d;
            acc_valid_q <= acc_valid_d;
            acc_last_q  <= acc_last_d;
            acc_row_q   <= acc_row_d;
            acc_col_q   <= acc_col_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = acc_valid_q & acc_last_q;
    assign out_row   = acc_row_q;
    assign out_col   = acc_col_q;
    assign out_acc   = acc_q;

endmodule

// File: rtl/mac_matmul.sv
// ---------------------------------------------------------------------------
// mac_matmul
// Self-starting SIZE x SIZE matrix multiply C = A x B over fixed matrices
// A[i][j] = i*SIZE+j+1 and B[i][j] = (i <= j). One (i,j,k) triple is issued
// per cycle (k innermost), fed through S1 operand registers into mac_pe, and
// each finished element is written into C one cycle after S3 completes it.
// Ports:
//   clk, reset         clock, asynchronous active-high reset (full abort)
//   done               high once all of C is written, until reset
//   res_valid          one-cycle pulse per C element written
//   res_row, res_col   index of the element written
//   res_data           value of the element written
// ---------------------------------------------------------------------------
module mac_matmul
    import mac_pkg::*;
#(
    parameter  int SIZE   = 4,
    parameter  int DATA_W = 8,
    localparam int ACC_W  = acc_width(DATA_W, SIZE),
    localparam int IDX_W  = clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             done,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_row,
    output logic [IDX_W-1:0] res_col,
    output logic [ACC_W-1:0] res_data
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SIZE - 1);

    state_e state_q, state_d;

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] k_q, k_d;

    logic [DATA_W-1:0] a_q [SIZE][SIZE];
    logic [DATA_W-1:0] a_d [SIZE][SIZE];
    logic [DATA_W-1:0] b_q [SIZE][SIZE];
    logic [DATA_W-1:0] b_d [SIZE][SIZE];
    logic [ACC_W-1:0]  c_q [SIZE][SIZE];
    logic [ACC_W-1:0]  c_d [SIZE][SIZE];

    // S1 operand registers
    logic              s1_valid_q, s1_valid_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_last_q,  s1_last_d;
    logic [IDX_W-1:0]  s1_row_q,   s1_row_d;
    logic [IDX_W-1:0]  s1_col_q,   s1_col_d;
    logic [DATA_W-1:0] s1_a_q,     s1_a_d;
    logic [DATA_W-1:0] s1_b_q,     s1_b_d;

    // Write stage
    logic              res_valid_q, res_valid_d;
    logic [IDX_W-1:0]  res_row_q,   res_row_d;
    logic [IDX_W-1:0]  res_col_q,   res_col_d;
    logic [ACC_W-1:0]  res_data_q,  res_data_d;

    logic              pe_valid;
    logic [IDX_W-1:0]  pe_row;
    logic [IDX_W-1:0]  pe_col;
    logic [ACC_W-1:0]  pe_acc;

    mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .IDX_W  (IDX_W)
    ) u_pe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid_q),
        .in_first  (s1_first_q),
        .in_last   (s1_last_q),
        .in_row    (s1_row_q),
        .in_col    (s1_col_q),
        .in_a      (s1_a_q),
        .in_b      (s1_b_q),
        .out_valid (pe_valid),
        .out_row   (pe_row),
        .out_col   (pe_col),
        .out_acc   (pe_acc)
    );

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;

        s1_valid_d  = 1'b0;
        s1_first_d  = (k_q == '0);
        s1_last_d   = (k_q == IDX_MAX);
        s1_row_d    = i_q;
        s1_col_d    = j_q;
        s1_a_d      = a_q[i_q][k_q];
        s1_b_d      = b_q[k_q][j_q];

        res_valid_d = 1'b0;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        res_data_d  = res_data_q;

        case (state_q)
            ST_RUN: begin
                s1_valid_d = 1'b1;
                if (k_q != IDX_MAX) begin
                    k_d = k_q + IDX_W'(1);
                end else begin
                    k_d = '0;
                    if (j_q != IDX_MAX) begin
                        j_d = j_q + IDX_W'(1);
                    end else begin
                        j_d = '0;
                        if (i_q != IDX_MAX) begin
                            i_d = i_q + IDX_W'(1);
                        end else begin
                            i_d     = '0;
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // The final element is the last write; leave once it is out.
                if (res_valid_q && res_row_q == IDX_MAX && res_col_q == IDX_MAX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (pe_valid && state_q != ST_DONE) begin
            res_valid_d        = 1'b1;
            res_row_d          = pe_row;
            res_col_d          = pe_col;
            res_data_d         = pe_acc;
            c_d[pe_row][pe_col] = pe_acc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            // NOTE: storage arrays are normally left unreset; here A/B get their fixed contents and C is cleared because reset defines them.
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    a_q[r][c] <= DATA_W'(r * SIZE + c + 1);
                    b_q[r][c] <= (r <= c) ? DATA_W'(1) : '0;
                    c_q[r][c] <= '0;
                end
            end
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            res_valid_q <= res_valid_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            res_data_q  <= res_data_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign res_valid = res_valid_q;
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_matmul.sv
// ---------------------------------------------------------------------------
// tb_mac_matmul
// Runs a SIZE=4 and a SIZE=2 instance from a shared clock and reset. A
// negedge monitor compares every cycle against a reference derived from the
// matrix definitions and the result schedule (element n of C appears after
// edge SIZE+2+n*SIZE, done from edge SIZE^3+3). Full runs, a fixed mid-run
// abort and a randomly placed abort are exercised.
// ---------------------------------------------------------------------------
module tb_mac_matmul;

    logic        clk;
    logic        reset;

    logic        done4, rv4;
    logic [1:0]  row4, col4;
    logic [17:0] data4;

    logic        done2, rv2;
    logic [0:0]  row2, col2;
    logic [16:0] data2;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;
    bit mon_en   = 0;
    int cnt4, cnt2;
    longint cap4 [4][4];
    longint cap2 [2][2];

    mac_matmul #(.SIZE(4), .DATA_W(8)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .done      (done4),
        .res_valid (rv4),
        .res_row   (row4),
        .res_col   (col4),
        .res_data  (data4)
    );

    mac_matmul #(.SIZE(2), .DATA_W(8)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .done      (done2),
        .res_valid (rv2),
        .res_row   (row2),
        .res_col   (col2),
        .res_data  (data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Index of the most recent rising edge since reset release (-1 before edge 0).
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= -1;
        else       edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // C[i][j] from the matrix definitions.
    function automatic longint c_ref(input int size, input int i, input int j);
        longint s;
        s = 0;
        for (int k = 0; k < size; k++) begin
            s += longint'(i * size + k + 1) * ((k <= j) ? 1 : 0);
        end
        return s;
    endfunction

    function automatic bit exp_valid(input int size, input int e);
        int first;
        first = size + 2;
        return (e >= first) && ((e - first) % size == 0) && ((e - first) / size < size * size);
    endfunction

    task automatic mon(input int size, input int e, input logic d, input logic v,
                       input int row, input int col, input logic [63:0] data);
        int n;
        check($sformatf("done_s%0d_e%0d", size, e), 64'(d), 64'(e >= size * size * size + 3));
        check($sformatf("valid_s%0d_e%0d", size, e), 64'(v), 64'(exp_valid(size, e)));
        if (exp_valid(size, e)) begin
            n = (e - size - 2) / size;
            check($sformatf("row_s%0d_e%0d", size, e), 64'(row), 64'(n / size));
            check($sformatf("col_s%0d_e%0d", size, e), 64'(col), 64'(n % size));
            check($sformatf("data_s%0d_e%0d", size, e), data, 64'(c_ref(size, n / size, n % size)));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && edge_n >= 0) begin
            mon(4, edge_n, done4, rv4, int'(row4), int'(col4), 64'(data4));
            mon(2, edge_n, done2, rv2, int'(row2), int'(col2), 64'(data2));
            if (rv4) begin
                cnt4++;
                cap4[row4][col4] = longint'(data4);
            end
            if (rv2) begin
                cnt2++;
                cap2[row2][col2] = longint'(data2);
            end
        end
    end

    task automatic clear_run();
        cnt4 = 0;
        cnt2 = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cap4[r][c] = -1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) cap2[r][c] = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done4"}, 64'(done4), 0);
        check({tag, "_valid4"}, 64'(rv4), 0);
        check({tag, "_row4"}, 64'(row4), 0);
        check({tag, "_col4"}, 64'(col4), 0);
        check({tag, "_data4"}, 64'(data4), 0);
        check({tag, "_done2"}, 64'(done2), 0);
        check({tag, "_valid2"}, 64'(rv2), 0);
        check({tag, "_data2"}, 64'(data2), 0);
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    // Runs to 100 cycles past done, then checks pulse counts and captured C.
    task automatic finish_run(input string tag);
        int row0 [4];
        int row3 [4];
        int c2 [4];
        row0 = '{1, 3, 6, 10};
        row3 = '{13, 27, 42, 58};
        c2   = '{1, 3, 3, 7};
        wait_edge(67 + 100);
        #1;
        check({tag, "_pulses4"}, 64'(cnt4), 16);
        check({tag, "_pulses2"}, 64'(cnt2), 4);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_c4_0_%0d", tag, c), 64'(cap4[0][c]), 64'(row0[c]));
            check($sformatf("%s_c4_3_%0d", tag, c), 64'(cap4[3][c]), 64'(row3[c]));
        end
        for (int n = 0; n < 4; n++)
            check($sformatf("%s_c2_%0d_%0d", tag, n / 2, n % 2), 64'(cap2[n / 2][n % 2]), 64'(c2[n]));
    endtask

    task automatic abort_at(input int e, input string tag);
        wait_edge(e);
        #2 reset = 1'b1;
        clear_run();
        #1 check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int rnd_edge;
        reset = 1'b1;
        clear_run();
        #7 check_reset_outputs("rst");
        #3 reset = 1'b0;
        mon_en = 1'b1;
        finish_run("run1");

        // Fixed abort mid-computation.
        #3 reset = 1'b1;
        clear_run();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        abort_at(30, "abort30");
        finish_run("run2");

        // Abort at a random point, possibly from DONE.
        rnd_edge = int'($urandom_range(1, 90));
        #3 reset = 1'b1;
        clear_run();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        abort_at(rnd_edge, "abort_rnd");
        finish_run("run3");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
